// File: rtl/mat_rd_arbiter.sv
// Round-robin owner arbiter for a shared matrix-storage read port.
// The owner holds the port until it drops its lock with no read outstanding.
module mat_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_rd_en,
  input  logic [NUM_REQ-1:0]           req_slot,
  input  logic [NUM_REQ*DIM_WIDTH-1:0] req_row,
  input  logic [NUM_REQ*DIM_WIDTH-1:0] req_col,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [DATA_WIDTH-1:0]        req_elem,
  output logic [NUM_REQ-1:0]           req_elem_valid,
  output logic                         mem_rd_en,
  output logic                         mem_slot,
  output logic [DIM_WIDTH-1:0]         mem_row,
  output logic [DIM_WIDTH-1:0]         mem_col,
  input  logic [DATA_WIDTH-1:0]        mem_elem,
  input  logic                         mem_elem_valid,
  output logic [2:0]                   owner_idx,
  output logic                         arb_busy,
  output logic                         viol,
  output logic                         timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [2:0]          r_owner;
  logic [2:0]          r_last;
  logic                r_pend;
  logic [TW-1:0]       r_tcnt;
  logic                r_busy;
  logic                r_viol;
  logic                r_tout;

  logic                w_found;
  logic [2:0]          w_sel;
  logic [3:0]          w_cand;
  logic                w_lock_owner;
  logic                w_rd_owner;
  logic                w_mem_rd_en;
  logic                w_viol;

  // Rotating search starting just after the previous owner.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = {1'b0, r_last} + 4'(i);
      if (w_cand >= 4'(NUM_REQ))
        w_cand = w_cand - 4'(NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (w_cand == 4'(j)) && req_lock[j]) begin
          w_found = 1'b1;
          w_sel   = 3'(j);
        end
      end
    end
  end

  // r_gnt is zero outside S_HOLD, so it doubles as the owner select mask.
  assign w_lock_owner = |(req_lock & r_gnt);
  assign w_rd_owner   = |(req_rd_en & r_gnt);
  assign w_viol       = (|(req_rd_en & ~r_gnt)) | (w_rd_owner & r_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_HOLD;
      S_HOLD:    if (!w_lock_owner && !r_pend && !w_mem_rd_en) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_rd_en = 1'b0;
    mem_slot    = 1'b0;
    mem_row     = '0;
    mem_col     = '0;
    if (r_state == S_HOLD) begin
      w_mem_rd_en = w_rd_owner & ~r_pend;
      mem_slot    = |(req_slot & r_gnt);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (r_gnt[j]) begin
          mem_row = mem_row | req_row[j*DIM_WIDTH +: DIM_WIDTH];
          mem_col = mem_col | req_col[j*DIM_WIDTH +: DIM_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= 3'(NUM_REQ - 1);
      r_pend  <= 1'b0;
      r_tcnt  <= '0;
      r_busy  <= 1'b0;
      r_viol  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_viol <= w_viol;
      r_tout <= 1'b0;
      if (r_state == S_IDLE && w_found) begin
        r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
        r_owner <= w_sel;
        r_last  <= w_sel;
      end else if (r_state == S_HOLD && w_next == S_RELEASE) begin
        r_gnt <= '0;
      end
      if (w_mem_rd_en) begin
        r_pend <= 1'b1;
        r_tcnt <= '0;
      end else if (r_pend) begin
        if (mem_elem_valid) begin
          r_pend <= 1'b0;
          r_tcnt <= '0;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          r_pend <= 1'b0;
          r_tcnt <= '0;
          r_tout <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  assign mem_rd_en      = w_mem_rd_en;
  assign gnt            = r_gnt;
  assign owner_idx      = r_owner;
  assign arb_busy       = r_busy;
  assign viol           = r_viol;
  assign timeout_err    = r_tout;
  assign req_elem       = mem_elem;
  assign req_elem_valid = r_gnt & {NUM_REQ{mem_elem_valid & r_pend}};

endmodule

// File: tb/tb_mat_rd_arbiter.sv
// Scenario bench for mat_rd_arbiter: arbitration order, read pass-through,
// violations, timeout and asynchronous reset.
module tb_mat_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_lock, req_rd_en, req_slot;
  logic [11:0] req_row, req_col;
  logic [3:0]  gnt, req_elem_valid;
  logic [7:0]  req_elem, mem_elem;
  logic        mem_rd_en, mem_slot, mem_elem_valid;
  logic [2:0]  mem_row, mem_col, owner_idx;
  logic        arb_busy, viol, timeout_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_data_q[$];
  logic [3:0] exp_vld_q[$];

  always #5 clk = ~clk;

  mat_rd_arbiter #(.NUM_REQ(4), .DIM_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_lock(req_lock), .req_rd_en(req_rd_en),
    .req_slot(req_slot), .req_row(req_row), .req_col(req_col), .gnt(gnt),
    .req_elem(req_elem), .req_elem_valid(req_elem_valid), .mem_rd_en(mem_rd_en),
    .mem_slot(mem_slot), .mem_row(mem_row), .mem_col(mem_col), .mem_elem(mem_elem),
    .mem_elem_valid(mem_elem_valid), .owner_idx(owner_idx), .arb_busy(arb_busy),
    .viol(viol), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_lock = 4'b0101; req_rd_en = '0; req_slot = '0;
    req_row = '0; req_col = '0; mem_elem = '0; mem_elem_valid = 1'b0;
    tick(); tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if ({arb_busy, viol, timeout_err, mem_rd_en} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {arb_busy, viol, timeout_err, mem_rd_en}); end
    total++; if (owner_idx !== 3'd0) begin bad++; $display("FAIL rst_owner got=%0d exp=0", owner_idx); end
    rst = 1'b0;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
    total++; if (owner_idx !== 3'd0 || arb_busy !== 1'b1) begin bad++; $display("FAIL first_owner got=%0d/%b exp=0/1", owner_idx, arb_busy); end
  endtask

  task automatic test_handover();
    req_lock = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0000 || arb_busy !== 1'b1) begin bad++; $display("FAIL release_cycle got=%b/%b exp=0000/1", gnt, arb_busy); end
    tick();
    total++; if (gnt !== 4'b0000 || arb_busy !== 1'b0) begin bad++; $display("FAIL idle_cycle got=%b/%b exp=0000/0", gnt, arb_busy); end
    tick();
    total++; if (gnt !== 4'b0100 || owner_idx !== 3'd2) begin bad++; $display("FAIL handover_gnt got=%b/%0d exp=0100/2", gnt, owner_idx); end
    req_lock = 4'b0101;
  endtask

  task automatic test_read();
    logic [2:0] rows[4]  = '{3'd1, 3'd7, 3'd0, 3'd5};
    logic [2:0] cols[4]  = '{3'd2, 3'd0, 3'd7, 3'd3};
    logic       slots[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] dats[4]  = '{8'h5A, 8'hFF, 8'h00, 8'hC3};
    logic [7:0] d;
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      // other requesters carry decoy indices that must not reach the port
      req_row = {3'd6, rows[k], 3'd3, 3'd4};
      req_col = {3'd1, cols[k], 3'd6, 3'd5};
      req_slot = {~slots[k], slots[k], ~slots[k], ~slots[k]};
      req_rd_en = 4'b0100;
      #1;
      total++; if (mem_rd_en !== 1'b1 || mem_row !== rows[k] || mem_col !== cols[k] || mem_slot !== slots[k]) begin
        bad++; $display("FAIL rd_port[%0d] got=%b/%0d/%0d/%b exp=1/%0d/%0d/%b", k, mem_rd_en, mem_row, mem_col, mem_slot, rows[k], cols[k], slots[k]);
      end
      exp_data_q.push_back(dats[k]);
      exp_vld_q.push_back(4'b0100);
      tick();
      req_rd_en = '0; mem_elem = dats[k]; mem_elem_valid = 1'b1;
      #1;
      total++;
      if (req_elem_valid !== 4'b0000 && exp_vld_q.size() > 0) begin
        d = exp_data_q.pop_front();
        v = exp_vld_q.pop_front();
        if (req_elem !== d || req_elem_valid !== v) begin bad++; $display("FAIL rd_data[%0d] got=%h/%b exp=%h/%b", k, req_elem, req_elem_valid, d, v); end
      end else begin
        bad++; $display("FAIL rd_valid[%0d] got=%b exp=0100", k, req_elem_valid);
      end
      total++; if (viol !== 1'b0) begin bad++; $display("FAIL rd_noviol[%0d] got=%b exp=0", k, viol); end
      tick();
      mem_elem_valid = 1'b0;
    end
    mem_elem = 8'hAA; mem_elem_valid = 1'b1;
    #1;
    total++; if (req_elem_valid !== 4'b0000) begin bad++; $display("FAIL stray_drop got=%b exp=0000", req_elem_valid); end
    tick();
    mem_elem_valid = 1'b0;
  endtask

  task automatic test_rotate_back();
    req_lock = 4'b0001;
    tick(); tick(); tick();
    total++; if (gnt !== 4'b0001 || owner_idx !== 3'd0) begin bad++; $display("FAIL round2_gnt got=%b/%0d exp=0001/0", gnt, owner_idx); end
  endtask

  task automatic test_viol();
    int n;
    req_lock = 4'b0010;
    n = 0;
    while (gnt !== 4'b0010 && n < 8) begin tick(); n++; end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL owner1_gnt got=%b exp=0010", gnt); end
    req_rd_en = 4'b1000;
    #1;
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL nonowner_block got=%b exp=0", mem_rd_en); end
    tick();
    req_rd_en = '0;
    total++; if (viol !== 1'b1) begin bad++; $display("FAIL nonowner_viol got=%b exp=1", viol); end
    tick();
    total++; if (viol !== 1'b0) begin bad++; $display("FAIL viol_pulse got=%b exp=0", viol); end
    // owner issues a second read while the first is outstanding
    req_rd_en = 4'b0010;
    tick();
    #1;
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL pend_block got=%b exp=0", mem_rd_en); end
    tick();
    req_rd_en = '0;
    total++; if (viol !== 1'b1) begin bad++; $display("FAIL pend_viol got=%b exp=1", viol); end
    exp_data_q.push_back(8'h3C);
    exp_vld_q.push_back(4'b0010);
    mem_elem = 8'h3C; mem_elem_valid = 1'b1;
    #1;
    total++;
    if (req_elem_valid !== 4'b0000 && exp_vld_q.size() > 0) begin
      if (req_elem !== exp_data_q[0] || req_elem_valid !== exp_vld_q[0]) begin bad++; $display("FAIL owner1_data got=%h/%b exp=%h/%b", req_elem, req_elem_valid, exp_data_q[0], exp_vld_q[0]); end
      void'(exp_data_q.pop_front());
      void'(exp_vld_q.pop_front());
    end else begin
      bad++; $display("FAIL owner1_valid got=%b exp=0010", req_elem_valid);
    end
    tick();
    mem_elem_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int first;
    first = -1;
    req_rd_en = 4'b0010;
    tick();
    req_rd_en = '0;
    for (int n = 1; n <= 20 && first < 0; n++) begin
      tick();
      if (timeout_err === 1'b1) first = n;
    end
    total++; if (first != 15) begin bad++; $display("FAIL timeout_cycle got=%0d exp=15", first); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL timeout_hold got=%b exp=0010", gnt); end
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b exp=0", timeout_err); end
    req_lock = '0;
    tick();
    total++; if (gnt !== 4'b0000 || arb_busy !== 1'b1) begin bad++; $display("FAIL timeout_release got=%b/%b exp=0000/1", gnt, arb_busy); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n;
    req_lock = 4'b0001;
    n = 0;
    while (gnt !== 4'b0001 && n < 8) begin tick(); n++; end
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt got=%b exp=0001", gnt); end
    req_rd_en = 4'b0001;
    tick();
    req_rd_en = '0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000 || arb_busy !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%b exp=0000/0", gnt, arb_busy); end
    tick();
    rst = 1'b0; req_lock = '0; mem_elem = 8'h77; mem_elem_valid = 1'b1;
    #1;
    total++; if (req_elem_valid !== 4'b0000) begin bad++; $display("FAIL post_rst_drop got=%b exp=0000", req_elem_valid); end
    tick();
    mem_elem_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handover();
    test_read();
    test_rotate_back();
    test_viol();
    test_timeout();
    test_reset_mid();
    total++; if (exp_data_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_data_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mat_rd_arbiter.md
MAT_RD_ARBITER -- requirements
Module: mat_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the matrix storage read port (2..8).
REQ-002 Parameter DIM_WIDTH, default 3, row/column index width.
REQ-003 Parameter DATA_WIDTH, default 8, element width.
REQ-004 Parameter TIMEOUT, default 15, max cycles a read may stay outstanding.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req_lock  input  NUM_REQ  per-requester ownership request (requester busy), level.
REQ-009 req_rd_en  input  NUM_REQ  per-requester single-cycle read strobe.
REQ-010 req_slot  input  NUM_REQ  per-requester slot index, bit i for requester i.
REQ-011 req_row / req_col  input  NUM_REQ*DIM_WIDTH each  per-requester indices, requester i at bits [i*DIM_WIDTH +: DIM_WIDTH].
REQ-012 gnt  output  NUM_REQ  one-hot (or zero) grant, registered.
REQ-013 req_elem  output  DATA_WIDTH  read data broadcast to all requesters.
REQ-014 req_elem_valid  output  NUM_REQ  one-hot data-valid routed to owner only.
REQ-015 mem_rd_en / mem_slot / mem_row / mem_col  output  1/1/DIM_WIDTH/DIM_WIDTH  storage read port.
REQ-016 mem_elem / mem_elem_valid  input  DATA_WIDTH/1  storage read return.
REQ-017 owner_idx  output  3  index of current owner; arb_busy  output  1  high while not IDLE.
REQ-018 viol  output  1  one-cycle pulse: non-owner asserted rd_en; timeout_err  output  1  one-cycle pulse on read timeout.

Function
REQ-019 States: S_IDLE, S_HOLD, S_RELEASE, encoded 2 bits.
REQ-020 S_IDLE: if any req_lock high, select first requester with lock high searching from (last_owner+1) mod NUM_REQ upward with wrap; register owner_idx, last_owner, gnt one-hot; go S_HOLD; grant visible the cycle after lock first sampled.
REQ-021 S_IDLE with no lock: gnt=0, stay.
REQ-022 S_HOLD: mem_rd_en = req_rd_en[owner] combinationally; mem_slot/row/col muxed from owner's fields; zero-latency pass-through.
REQ-023 Outstanding flag pend set on mem_rd_en, cleared on mem_elem_valid; a new mem_rd_en while pend is high is blocked (mem_rd_en forced 0) and pulses viol.
REQ-024 req_elem = mem_elem; req_elem_valid[owner] = mem_elem_valid & pend, all other bits 0; mem_elem_valid with pend low is dropped.
REQ-025 S_HOLD -> S_RELEASE when req_lock[owner] low and pend low; if lock drops while pend high, stay until return or timeout.
REQ-026 S_RELEASE: gnt=0 for exactly one cycle, then S_IDLE; guarantees no back-to-back owner overlap.
REQ-027 Timeout counter (width ceil(log2(TIMEOUT+1))) counts cycles with pend high, reset on clear; at TIMEOUT: clear pend, pulse timeout_err, stay in S_HOLD.
REQ-028 Any req_rd_en bit of a non-owner (or any bit in S_IDLE/S_RELEASE) pulses viol next cycle and is not forwarded.
REQ-029 arb_busy = (state != S_IDLE), registered.
REQ-030 Owner cannot be preempted; fairness solely via rotating pointer.

Reset
REQ-031 On rst: state S_IDLE, gnt=0, owner_idx=0, last_owner=NUM_REQ-1 (requester 0 highest priority first), pend=0, timeout counter=0, arb_busy=0, viol=0, timeout_err=0; combinational outputs then 0.
REQ-032 rst mid-operation drops grant immediately (asynchronous); in-flight return after reset is dropped per REQ-024.

Verification
REQ-033 Reset, lock=4'b0101 same cycle -> gnt=4'b0001 next cycle, owner_idx=0, arb_busy=1.
REQ-034 Requester 0 releases, locks 0 and 2 held -> one S_RELEASE cycle gnt=0, then gnt=4'b0100; next round gnt=4'b0001.
REQ-035 Owner 2 rd_en row=1 col=2 slot=1, memory returns 0x5A next cycle -> mem_row=1, mem_col=2, req_elem=0x5A, req_elem_valid=4'b0100.
REQ-036 Requester 3 asserts rd_en while 1 owns -> mem_rd_en=0, viol pulses one cycle, no valid to 3.
REQ-037 Owner reads, memory never responds -> timeout_err at 15 cycles, pend cleared, lock drop then releases.
REQ-038 rst asserted in S_HOLD with pend high -> gnt=0 immediately; later mem_elem_valid produces req_elem_valid=0.
